// File: rtl/v68k_bus_pkg.sv
// Shared definitions for the bus responder.
// Covers the FSM encoding, the bus direction codes, the latched request and the address-window test.
package v68k_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DECODE = 3'd1,
    ST_WAIT   = 3'd2,
    ST_ACK    = 3'd3,
    ST_ERR    = 3'd4
  } state_t;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  localparam int WAIT_CNT_W = 4;
  typedef logic [WAIT_CNT_W-1:0] wait_cnt_t;

  // Bus request as captured in IDLE; later changes on the bus are ignored.
  typedef struct packed {
    logic [23:1] a;
    logic        uds;
    logic        lds;
    logic        rw;
  } bus_req_t;

  // Byte-address window test [base, base + 2*depth), done one bit wider so the top end cannot wrap.
  function automatic logic in_window(input logic [23:1] a,
                                     input logic [23:0] base,
                                     input int unsigned depth);
    logic [24:0] byte_addr;
    logic [24:0] lo;
    logic [24:0] hi;
    byte_addr = {1'b0, a, 1'b0};
    lo        = {1'b0, base};
    hi        = lo + 25'(2 * depth);
    return (byte_addr >= lo) && (byte_addr < hi);
  endfunction

endpackage

// File: rtl/byte_lane_ram.sv
// 16-bit word RAM with independent upper/lower byte write enables and a registered read port.
// One address serves both read and write. A read returns the full word, whatever the lanes are.
module byte_lane_ram #(
  parameter int unsigned DEPTH_WORDS = 1024
) (
  input  logic                           clk,
  input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
  input  logic                           rd_en,
  input  logic [1:0]                     wr_en,
  input  logic [15:0]                    wdata,
  output logic [15:0]                    rdata
);

  logic [15:0] mem [DEPTH_WORDS];

  // NOTE: neither the array nor the read register is reset; a reset term would prevent RAM inference, and the contents must survive RESET.
  always_ff @(posedge clk) begin
    if (wr_en[1]) mem[addr][15:8] <= wdata[15:8];
    if (wr_en[0]) mem[addr][7:0]  <= wdata[7:0];
    if (rd_en)    rdata           <= mem[addr];
  end

endmodule

// File: rtl/bus_responder.sv
// Target side of the CPU bus. It decodes an address window and inserts WAIT_STATES cycles.
// It then acknowledges with DTACK and serves a byte-lane RAM; accesses outside the window end with BERR.
module bus_responder
  import v68k_bus_pkg::*;
#(
  parameter logic [23:0] ADDR_BASE   = 24'h000000,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [23:1] A,
  input  logic        UDS,
  input  logic        LDS,
  input  logic        AS,
  input  logic        RW,
  input  logic [15:0] D_IN,
  output logic [15:0] D_OUT,
  output logic        D_OE,
  output logic        DTACK,
  output logic        BERR
);

  localparam int        AW        = $clog2(DEPTH_WORDS);
  localparam wait_cnt_t WAIT_INIT = wait_cnt_t'(WAIT_STATES);

  state_t    state;
  wait_cnt_t cnt;
  bus_req_t  req;
  logic      oe_q;

  logic        in_win;
  logic        last_cycle;
  logic        go_ack;
  logic        ram_rd;
  logic [1:0]  ram_we;
  logic [15:0] ram_q;

  assign in_win = in_window(req.a, ADDR_BASE, DEPTH_WORDS);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    last_cycle = 1'b0;
    case (state)
      ST_DECODE: last_cycle = (WAIT_STATES == 0);
      ST_WAIT:   last_cycle = (cnt == wait_cnt_t'(1));
      default:   last_cycle = 1'b0;
    endcase
  end

  // The ACK-entry edge is the only edge that touches the RAM. A write therefore happens completely or not at all.
  assign go_ack = last_cycle && AS && in_win;
  assign ram_rd = go_ack && (req.rw == RW_READ);
  assign ram_we = (go_ack && (req.rw == RW_WRITE)) ? {req.uds, req.lds} : 2'b00;

  byte_lane_ram #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_ram (
    .clk  (CLK),
    .addr (req.a[AW:1]),
    .rd_en(ram_rd),
    .wr_en(ram_we),
    .wdata(D_IN),
    .rdata(ram_q)
  );

  // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= ST_IDLE;
      cnt   <= '0;
      req   <= '0;
      DTACK <= 1'b0;
      BERR  <= 1'b0;
      oe_q  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (AS) begin
            req   <= '{a: A, uds: UDS, lds: LDS, rw: RW};
            state <= ST_DECODE;
          end
        end

        ST_DECODE: begin
          if (!AS) begin
            state <= ST_IDLE;
          end else if (!in_win) begin
            state <= ST_ERR;
            BERR  <= 1'b1;
          end else if (go_ack) begin
            state <= ST_ACK;
            DTACK <= 1'b1;
            oe_q  <= (req.rw == RW_READ);
          end else begin
            state <= ST_WAIT;
            cnt   <= WAIT_INIT;
          end
        end

        ST_WAIT: begin
          if (!AS) begin
            state <= ST_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt - wait_cnt_t'(1);
            if (go_ack) begin
              state <= ST_ACK;
              DTACK <= 1'b1;
              oe_q  <= (req.rw == RW_READ);
            end
          end
        end

        ST_ACK: begin
          if (!AS) begin
            state <= ST_IDLE;
            DTACK <= 1'b0;
            oe_q  <= 1'b0;
          end
        end

        ST_ERR: begin
          if (!AS) begin
            state <= ST_IDLE;
            BERR  <= 1'b0;
          end
        end

        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
          DTACK <= 1'b0;
          BERR  <= 1'b0;
          oe_q  <= 1'b0;
        end
      endcase
    end
  end

  // The RAM read register lands on the ACK-entry edge. Gating it with oe_q gives D_OUT the same reset and release timing as D_OE.
  assign D_OE  = oe_q;
  assign D_OUT = oe_q ? ram_q : 16'h0000;

endmodule

// File: tb/tb_bus_responder.sv
// Directed and randomized bench for bus_responder with three instances.
// The instances are zero-wait, three-wait, and a window based at 24'h010000.
module tb_bus_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:1] a;
  logic        uds;
  logic        lds;
  logic        rw;
  logic [15:0] d_in;

  logic        as_v  [3];
  logic [15:0] d_out [3];
  logic        d_oe  [3];
  logic        dtack [3];
  logic        berr  [3];

  int n_checks = 0;
  int n_fail   = 0;

  localparam int WS [3] = '{0, 3, 0};

  logic [15:0] model [2][16];

  always #5 clk = ~clk;

  bus_responder #(.ADDR_BASE(24'h000000), .DEPTH_WORDS(1024), .WAIT_STATES(0)) u0 (
    .CLK(clk), .RESET(rst), .A(a), .UDS(uds), .LDS(lds), .AS(as_v[0]), .RW(rw),
    .D_IN(d_in), .D_OUT(d_out[0]), .D_OE(d_oe[0]), .DTACK(dtack[0]), .BERR(berr[0]));

  bus_responder #(.ADDR_BASE(24'h000000), .DEPTH_WORDS(1024), .WAIT_STATES(3)) u1 (
    .CLK(clk), .RESET(rst), .A(a), .UDS(uds), .LDS(lds), .AS(as_v[1]), .RW(rw),
    .D_IN(d_in), .D_OUT(d_out[1]), .D_OE(d_oe[1]), .DTACK(dtack[1]), .BERR(berr[1]));

  bus_responder #(.ADDR_BASE(24'h010000), .DEPTH_WORDS(1024), .WAIT_STATES(0)) u2 (
    .CLK(clk), .RESET(rst), .A(a), .UDS(uds), .LDS(lds), .AS(as_v[2]), .RW(rw),
    .D_IN(d_in), .D_OUT(d_out[2]), .D_OE(d_oe[2]), .DTACK(dtack[2]), .BERR(berr[2]));

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // DTACK and BERR must never overlap, and D_OE may only be high while DTACK is high.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      check("dtack_berr_excl", {15'b0, dtack[i] && berr[i]}, 16'h0000);
      check("oe_only_in_ack",  {15'b0, d_oe[i] && !dtack[i]}, 16'h0000);
    end
  end

  // One complete bus cycle, started on a negedge. It checks response latency and outputs, then the release one edge after AS drops.
  task automatic bus_cycle(input int inst, input logic [23:1] addr, input logic is_read,
                           input logic u, input logic l, input logic [15:0] wdata,
                           input logic exp_err, input logic [15:0] exp_rdata, input string tag);
    int          lat;
    int          exp_lat;
    logic [15:0] exp_out;
    exp_lat = exp_err ? 1 : 1 + WS[inst];
    exp_out = (!exp_err && is_read) ? exp_rdata : 16'h0000;
    a = addr; rw = is_read; uds = u; lds = l; d_in = wdata;
    as_v[inst] = 1'b1;
    lat = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (k == 0) begin
        a = ~addr; rw = ~is_read; uds = ~u; lds = ~l;
      end
      if (dtack[inst] || berr[inst]) begin
        lat = k;
        break;
      end
    end
    check({tag, "_latency"}, 16'(lat), 16'(exp_lat));
    check({tag, "_dtack"}, {15'b0, dtack[inst]}, {15'b0, !exp_err});
    check({tag, "_berr"},  {15'b0, berr[inst]},  {15'b0, exp_err});
    check({tag, "_d_oe"},  {15'b0, d_oe[inst]},  {15'b0, !exp_err && is_read});
    check({tag, "_d_out"}, d_out[inst], exp_out);
    as_v[inst] = 1'b0;
    @(negedge clk);
    check({tag, "_rel_dtack"}, {15'b0, dtack[inst]}, 16'h0000);
    check({tag, "_rel_berr"},  {15'b0, berr[inst]},  16'h0000);
    check({tag, "_rel_d_out"}, d_out[inst], 16'h0000);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] wd;
    logic [3:0]  ra;
    logic        rd;
    logic        ru;
    logic        rl;
    int          ri;
    int          lat;

    rst = 1'b1; a = '0; uds = 1'b0; lds = 1'b0; rw = 1'b1; d_in = '0;
    for (int i = 0; i < 3; i++) as_v[i] = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check("reset_dtack", {15'b0, dtack[i]}, 16'h0000);
      check("reset_berr",  {15'b0, berr[i]},  16'h0000);
      check("reset_d_oe",  {15'b0, d_oe[i]},  16'h0000);
      check("reset_d_out", d_out[i], 16'h0000);
    end
    rst = 1'b0;
    @(negedge clk);

    // Read after write, no wait states.
    bus_cycle(0, 23'd5, 1'b0, 1'b1, 1'b1, 16'hBEEF, 1'b0, 16'h0000, "w_beef");
    bus_cycle(0, 23'd5, 1'b1, 1'b1, 1'b1, 16'h0000, 1'b0, 16'hBEEF, "r_beef");

    // Byte lanes, including a no-lane write that must leave the word alone.
    bus_cycle(0, 23'd6, 1'b0, 1'b1, 1'b1, 16'h1234, 1'b0, 16'h0000, "w_1234");
    bus_cycle(0, 23'd6, 1'b0, 1'b1, 1'b0, 16'hAB00, 1'b0, 16'h0000, "w_upper");
    bus_cycle(0, 23'd6, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 16'hAB34, "r_ab34");
    bus_cycle(0, 23'd6, 1'b0, 1'b0, 1'b1, 16'h00CD, 1'b0, 16'h0000, "w_lower");
    bus_cycle(0, 23'd6, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 16'hABCD, "r_abcd");
    bus_cycle(0, 23'd6, 1'b0, 1'b0, 1'b0, 16'hFFFF, 1'b0, 16'h0000, "w_nolane");
    bus_cycle(0, 23'd6, 1'b1, 1'b1, 1'b1, 16'h0000, 1'b0, 16'hABCD, "r_nolane");

    // Three wait states: latency, then a write aborted after edge 2 that must not land.
    bus_cycle(1, 23'd7, 1'b0, 1'b1, 1'b1, 16'h1111, 1'b0, 16'h0000, "ws_w");
    bus_cycle(1, 23'd7, 1'b1, 1'b1, 1'b1, 16'h0000, 1'b0, 16'h1111, "ws_r");
    a = 23'd7; rw = 1'b0; uds = 1'b1; lds = 1'b1; d_in = 16'hDEAD;
    as_v[1] = 1'b1;
    repeat (3) @(negedge clk);
    as_v[1] = 1'b0;
    repeat (6) begin
      @(negedge clk);
      check("abort_dtack", {15'b0, dtack[1]}, 16'h0000);
      check("abort_berr",  {15'b0, berr[1]},  16'h0000);
    end
    bus_cycle(1, 23'd7, 1'b1, 1'b1, 1'b1, 16'h0000, 1'b0, 16'h1111, "abort_r");

    // Window based at 24'h010000: word addresses 0x8000..0x83FF.
    bus_cycle(2, 23'h8000, 1'b0, 1'b1, 1'b1, 16'h5A5A, 1'b0, 16'h0000, "win_w_lo");
    bus_cycle(2, 23'h0000, 1'b0, 1'b1, 1'b1, 16'hFFFF, 1'b1, 16'h0000, "oow_w0");
    bus_cycle(2, 23'h8000, 1'b1, 1'b1, 1'b1, 16'h0000, 1'b0, 16'h5A5A, "win_r_lo");
    bus_cycle(2, 23'h8400, 1'b1, 1'b1, 1'b1, 16'h0000, 1'b1, 16'h0000, "oow_above");
    bus_cycle(2, 23'h7FFF, 1'b1, 1'b1, 1'b1, 16'h0000, 1'b1, 16'h0000, "oow_below");
    bus_cycle(2, 23'h83FF, 1'b0, 1'b1, 1'b1, 16'h0F0F, 1'b0, 16'h0000, "win_w_hi");
    bus_cycle(2, 23'h83FF, 1'b1, 1'b1, 1'b1, 16'h0000, 1'b0, 16'h0F0F, "win_r_hi");

    // Asynchronous reset while a read is being acknowledged.
    a = 23'd5; rw = 1'b1; uds = 1'b1; lds = 1'b1;
    as_v[0] = 1'b1;
    lat = -1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (dtack[0]) begin
        lat = k;
        break;
      end
    end
    check("rst_ack_latency", 16'(lat), 16'd1);
    check("rst_pre_d_out", d_out[0], 16'hBEEF);
    rst = 1'b1;
    #1;
    check("rst_async_dtack", {15'b0, dtack[0]}, 16'h0000);
    check("rst_async_d_oe",  {15'b0, d_oe[0]},  16'h0000);
    check("rst_async_berr",  {15'b0, berr[0]},  16'h0000);
    check("rst_async_d_out", d_out[0], 16'h0000);
    as_v[0] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    bus_cycle(0, 23'd5, 1'b1, 1'b1, 1'b1, 16'h0000, 1'b0, 16'hBEEF, "post_rst_r");

    // Scoreboard phase: seed words 0..15 in both instances, then random back-to-back traffic.
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 16; j++) begin
        wd = 16'($urandom);
        model[i][j] = wd;
        bus_cycle(i, 23'(j), 1'b0, 1'b1, 1'b1, wd, 1'b0, 16'h0000, "seed");
      end
    end
    for (int t = 0; t < 1000; t++) begin
      ri = int'($urandom_range(0, 1));
      ra = 4'($urandom_range(0, 15));
      rd = 1'($urandom);
      ru = 1'($urandom);
      rl = 1'($urandom);
      wd = 16'($urandom);
      if (rd) begin
        bus_cycle(ri, {19'b0, ra}, 1'b1, ru, rl, wd, 1'b0, model[ri][ra], "rand_r");
      end else begin
        bus_cycle(ri, {19'b0, ra}, 1'b0, ru, rl, wd, 1'b0, 16'h0000, "rand_w");
        if (ru) model[ri][ra][15:8] = wd[15:8];
        if (rl) model[ri][ra][7:0]  = wd[7:0];
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
